// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state and owner encodings for the memory-port arbiter.
// Both owner values are also the round-robin history values.
package mem_arbiter_pkg;

  localparam int PC_SIZE = 32;
  localparam int XLEN    = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_e;

  // The requester that did not win last time gets priority on a tie.
  function automatic arb_owner_e other_owner(input arb_owner_e o);
    return (o == ARB_OWN_IFU) ? ARB_OWN_LSU : ARB_OWN_IFU;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way combinational round-robin grant between the IFU and LSU.
// A lone requester always wins; on a tie, the requester not in last_grant wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       req_ifu,
  input  logic       req_lsu,
  input  arb_owner_e last_grant,
  output logic       gnt_ifu,
  output logic       gnt_lsu,
  output arb_owner_e winner
);

  arb_owner_e preferred;

  always_comb begin
    gnt_ifu   = 1'b0;
    gnt_lsu   = 1'b0;
    preferred = other_owner(last_grant);
    if (req_ifu && req_lsu) begin
      gnt_ifu = (preferred == ARB_OWN_IFU);
      gnt_lsu = (preferred == ARB_OWN_LSU);
    end else begin
      gnt_ifu = req_ifu;
      gnt_lsu = req_lsu;
    end
    winner = gnt_lsu ? ARB_OWN_LSU : ARB_OWN_IFU;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, with a
// single outstanding transaction and silent disposal of flushed fetches.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = PC_SIZE,
  parameter int DATA_W = XLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_pc,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rsp_instr,
  input  logic                ifu_flush,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);

  arb_state_e          state_reg, state_next;
  arb_owner_e          owner_reg, owner_next;
  arb_owner_e          last_grant_reg, last_grant_next;
  logic                drop_reg, drop_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                wen_reg, wen_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W/8-1:0] wmask_reg, wmask_next;

  logic       gnt_ifu, gnt_lsu;
  arb_owner_e winner;
  logic       flush_hit;
  logic       drop_eff;

  // A fetch raised together with a flush is already stale, so it never competes.
  rr_arb2 u_rr_arb2 (
    .req_ifu    (ifu_req_valid && !ifu_flush),
    .req_lsu    (lsu_req_valid),
    .last_grant (last_grant_reg),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu),
    .winner     (winner)
  );

  assign mem_req_addr  = addr_reg;
  assign mem_req_wen   = wen_reg;
  assign mem_req_wdata = wdata_reg;
  assign mem_req_wmask = wmask_reg;
  assign ifu_rsp_instr = mem_rsp_rdata;
  assign lsu_rsp_rdata = mem_rsp_rdata;

  assign flush_hit = ifu_flush && (owner_reg == ARB_OWN_IFU);

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    drop_next       = drop_reg;
    addr_next       = addr_reg;
    wen_next        = wen_reg;
    wdata_next      = wdata_reg;
    wmask_next      = wmask_reg;
    ifu_req_ready   = 1'b0;
    lsu_req_ready   = 1'b0;
    ifu_rsp_valid   = 1'b0;
    lsu_rsp_valid   = 1'b0;
    mem_req_valid   = 1'b0;
    mem_rsp_ready   = 1'b0;
    drop_eff        = drop_reg || flush_hit;

    case (state_reg)
      ARB_IDLE: begin
        ifu_req_ready = gnt_ifu;
        lsu_req_ready = gnt_lsu;
        if (gnt_ifu || gnt_lsu) begin
          owner_next = winner;
          drop_next  = 1'b0;
          state_next = ARB_ISSUE;
          if (winner == ARB_OWN_IFU) begin
            addr_next  = ifu_req_pc;
            wen_next   = 1'b0;
            wdata_next = '0;
            wmask_next = '0;
          end else begin
            addr_next  = lsu_req_addr;
            wen_next   = lsu_req_wen;
            wdata_next = lsu_req_wdata;
            wmask_next = lsu_req_wmask;
          end
        end
      end

      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        if (flush_hit) drop_next = 1'b1;
        if (mem_req_ready) state_next = ARB_WAIT;
      end

      ARB_WAIT: begin
        if (flush_hit) drop_next = 1'b1;
        if (owner_reg == ARB_OWN_IFU) begin
          if (drop_eff) begin
            mem_rsp_ready = 1'b1;
          end else begin
            ifu_rsp_valid = mem_rsp_valid;
            mem_rsp_ready = ifu_rsp_ready;
          end
        end else begin
          lsu_rsp_valid = mem_rsp_valid;
          mem_rsp_ready = lsu_rsp_ready;
        end
        if (mem_rsp_valid && mem_rsp_ready) begin
          last_grant_next = owner_reg;
          drop_next       = 1'b0;
          state_next      = ARB_IDLE;
        end
      end

      default: state_next = ARB_IDLE;
    endcase

    // Handshakes are suppressed during reset so nothing is accepted or forwarded.
    if (rst) begin
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= ARB_OWN_IFU;
      last_grant_reg <= ARB_OWN_LSU;
      drop_reg       <= 1'b0;
      addr_reg       <= '0;
      wen_reg        <= 1'b0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      drop_reg       <= drop_next;
      addr_reg       <= addr_next;
      wen_reg        <= wen_next;
      wdata_reg      <= wdata_next;
      wmask_reg      <= wmask_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory and both requesters,
// changing inputs on the falling edge and checking outputs 1ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_flush;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_flush(ifu_flush),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs changed after this are seen by the next rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_pc = '0; ifu_rsp_ready = 0; ifu_flush = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0;
    lsu_req_wmask = '0; lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;

    // Reset: readies stay low even with requests present.
    cyc();
    ifu_req_valid = 1; lsu_req_valid = 1; mem_rsp_valid = 1;
    #1;
    check("rst_ifu_req_ready", ifu_req_ready, 0);
    check("rst_lsu_req_ready", lsu_req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_rsp_ready", mem_rsp_ready, 0);
    cyc();
    rst = 0; ifu_req_valid = 0; lsu_req_valid = 0; mem_rsp_valid = 0;
    #1;
    check("rst_addr", mem_req_addr, 32'h0);
    check("rst_wen", mem_req_wen, 0);
    check("rst_wdata", mem_req_wdata, 32'h0);
    check("rst_wmask", mem_req_wmask, 4'h0);
    check("rst_mem_req_valid_after", mem_req_valid, 0);
    $display("txn reset done");

    // IFU-only fetch.
    cyc(); ifu_req_valid = 1; ifu_req_pc = 32'h8000_0000; #1;
    check("t1_ifu_req_ready", ifu_req_ready, 1);
    check("t1_lsu_req_ready", lsu_req_ready, 0);
    cyc(); ifu_req_valid = 0; mem_req_ready = 1; #1;
    check("t1_mem_req_valid", mem_req_valid, 1);
    check("t1_mem_req_addr", mem_req_addr, 32'h8000_0000);
    check("t1_mem_req_wen", mem_req_wen, 0);
    check("t1_mem_req_wmask", mem_req_wmask, 4'h0);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0413; ifu_rsp_ready = 1; #1;
    check("t1_mem_req_valid_wait", mem_req_valid, 0);
    check("t1_ifu_rsp_valid", ifu_rsp_valid, 1);
    check("t1_ifu_rsp_instr", ifu_rsp_instr, 32'h0000_0413);
    check("t1_lsu_rsp_valid", lsu_rsp_valid, 0);
    check("t1_mem_rsp_ready", mem_rsp_ready, 1);
    cyc(); mem_rsp_valid = 0; ifu_rsp_ready = 0; #1;
    check("t1_idle_mem_req_valid", mem_req_valid, 0);
    check("t1_idle_ifu_rsp_valid", ifu_rsp_valid, 0);
    $display("txn ifu fetch pc=80000000 done");

    // Fresh reset, then simultaneous requests: IFU first, LSU second.
    cyc(); rst = 1;
    cyc(); rst = 0;
    ifu_req_valid = 1; ifu_req_pc = 32'h8000_0004;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 0; #1;
    check("t2_tie_ifu_ready", ifu_req_ready, 1);
    check("t2_tie_lsu_ready", lsu_req_ready, 0);
    cyc(); ifu_req_valid = 0; mem_req_ready = 1; #1;
    check("t2_issue_lsu_ready", lsu_req_ready, 0);
    check("t2_issue_addr", mem_req_addr, 32'h8000_0004);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0013; ifu_rsp_ready = 1; #1;
    check("t2_ifu_rsp_valid", ifu_rsp_valid, 1);
    check("t2_lsu_rsp_valid_ifu", lsu_rsp_valid, 0);
    check("t2_wait_lsu_ready", lsu_req_ready, 0);
    cyc(); mem_rsp_valid = 0; ifu_rsp_ready = 0;
    ifu_req_valid = 1; ifu_req_pc = 32'h8000_0008; #1;
    check("t2_rr_lsu_ready", lsu_req_ready, 1);
    check("t2_rr_ifu_ready", ifu_req_ready, 0);
    cyc(); lsu_req_valid = 0; mem_req_ready = 1; #1;
    check("t2_lsu_addr", mem_req_addr, 32'h8000_1000);
    check("t2_lsu_wen", mem_req_wen, 0);
    check("t2_lsu_issue_ifu_ready", ifu_req_ready, 0);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEAD_BEEF; lsu_rsp_ready = 1; #1;
    check("t2_lsu_rsp_valid", lsu_rsp_valid, 1);
    check("t2_lsu_rsp_rdata", lsu_rsp_rdata, 32'hDEAD_BEEF);
    check("t2_ifu_rsp_valid_lsu", ifu_rsp_valid, 0);
    cyc(); mem_rsp_valid = 0; lsu_rsp_ready = 0; #1;
    check("t2_next_ifu_ready", ifu_req_ready, 1);
    ifu_req_valid = 0;
    $display("txn tie ifu pc=80000004 then lsu load 80001000 done");

    // LSU store with memory stalling three cycles.
    cyc(); #1;
    cyc(); lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1;
    lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 4'hF; #1;
    check("t3_lsu_ready", lsu_req_ready, 1);
    cyc(); lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1;
      #1;
      check("t3_stall_valid", mem_req_valid, 1);
      check("t3_stall_addr", mem_req_addr, 32'h8000_2000);
      check("t3_stall_wen", mem_req_wen, 1);
      check("t3_stall_wdata", mem_req_wdata, 32'h1234_5678);
      check("t3_stall_wmask", mem_req_wmask, 4'hF);
      if (i < 3) cyc();
    end
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0; lsu_rsp_ready = 1; #1;
    check("t3_ack_valid", lsu_rsp_valid, 1);
    check("t3_ack_ifu_valid", ifu_rsp_valid, 0);
    cyc(); mem_rsp_valid = 0; lsu_rsp_ready = 0;
    $display("txn lsu store 80002000 data 12345678 done");

    // IFU fetch flushed while waiting for the response.
    ifu_req_valid = 1; ifu_req_pc = 32'h8000_0010; #1;
    check("t4_ifu_ready", ifu_req_ready, 1);
    cyc(); ifu_req_valid = 0; mem_req_ready = 1;
    cyc(); mem_req_ready = 0; ifu_flush = 1; ifu_rsp_ready = 0; #1;
    check("t4_flush_ifu_rsp_valid", ifu_rsp_valid, 0);
    check("t4_flush_mem_rsp_ready", mem_rsp_ready, 1);
    cyc(); ifu_flush = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0ABC; #1;
    check("t4_drop_ifu_rsp_valid", ifu_rsp_valid, 0);
    check("t4_drop_mem_rsp_ready", mem_rsp_ready, 1);
    cyc(); mem_rsp_valid = 0; ifu_req_valid = 1; ifu_req_pc = 32'h8000_0014; ifu_flush = 1; #1;
    check("t4_flush_blocks_grant", ifu_req_ready, 0);
    cyc(); ifu_flush = 0; #1;
    check("t4_regrant", ifu_req_ready, 1);
    cyc(); ifu_req_valid = 0; mem_req_ready = 1; #1;
    check("t4_regrant_addr", mem_req_addr, 32'h8000_0014);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0093; ifu_rsp_ready = 1; #1;
    check("t4_regrant_rsp_valid", ifu_rsp_valid, 1);
    check("t4_regrant_instr", ifu_rsp_instr, 32'h0000_0093);
    cyc(); mem_rsp_valid = 0; ifu_rsp_ready = 0;
    $display("txn ifu flush pc=80000010 dropped, refetch 80000014 done");

    // LSU response backpressure, with IFU waiting.
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 0; #1;
    check("t5_lsu_ready", lsu_req_ready, 1);
    cyc(); lsu_req_valid = 0; mem_req_ready = 1;
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hCAFE_F00D;
    lsu_rsp_ready = 0; ifu_req_valid = 1; ifu_req_pc = 32'h8000_0018;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t5_bp_mem_rsp_ready", mem_rsp_ready, 0);
      check("t5_bp_lsu_rsp_valid", lsu_rsp_valid, 1);
      check("t5_bp_lsu_rsp_rdata", lsu_rsp_rdata, 32'hCAFE_F00D);
      check("t5_bp_ifu_ready", ifu_req_ready, 0);
      cyc();
    end
    lsu_rsp_ready = 1; #1;
    check("t5_release_mem_rsp_ready", mem_rsp_ready, 1);
    cyc(); mem_rsp_valid = 0; lsu_rsp_ready = 0; #1;
    check("t5_after_ifu_ready", ifu_req_ready, 1);
    $display("txn lsu load 80003000 with backpressure done");

    // Reset during WAIT abandons the fetch.
    cyc(); ifu_req_valid = 0; mem_req_ready = 1;
    cyc(); mem_req_ready = 0; rst = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_1111; ifu_rsp_ready = 1; #1;
    check("t6_rst_ifu_rsp_valid", ifu_rsp_valid, 0);
    check("t6_rst_mem_rsp_ready", mem_rsp_ready, 0);
    cyc(); rst = 0; mem_rsp_valid = 0; ifu_rsp_ready = 0; #1;
    check("t6_idle_mem_req_valid", mem_req_valid, 0);
    check("t6_idle_ifu_rsp_valid", ifu_rsp_valid, 0);
    check("t6_idle_lsu_rsp_valid", lsu_rsp_valid, 0);
    check("t6_idle_addr", mem_req_addr, 32'h0);
    cyc(); lsu_req_valid = 1; lsu_req_addr = 32'h8000_4000; #1;
    check("t6_lsu_ready", lsu_req_ready, 1);
    cyc(); lsu_req_valid = 0; mem_req_ready = 1; #1;
    check("t6_lsu_addr", mem_req_addr, 32'h8000_4000);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h55AA_55AA; lsu_rsp_ready = 1; #1;
    check("t6_lsu_rsp_valid", lsu_rsp_valid, 1);
    check("t6_lsu_rsp_rdata", lsu_rsp_rdata, 32'h55AA_55AA);
    cyc(); mem_rsp_valid = 0; lsu_rsp_ready = 0;
    $display("txn reset in wait, lsu load 80004000 done");

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
